// File: rtl/freelist_ctrl_pkg.sv
// Shared types and constants for the rename-stage free-list controller.
package freelist_ctrl_pkg;

    // Flush-recovery sequencer states.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_ROLLBACK = 2'd2,
        ST_SETTLE   = 2'd3
    } fl_state_e;

    // Free-PR count after reset or rollback: everything not holding an architectural mapping.
    function automatic int unsigned fl_rst_cnt(input int unsigned prf_aw, input int unsigned n_arf);
        return (32'd1 << prf_aw) - n_arf;
    endfunction

endpackage

// File: rtl/freelist_ctrl_popcnt.sv
// Population count of a DW-bit mask; used for rename demand and commit frees.
module popcnt #(
    parameter int unsigned DW = 2
) (
    input  logic [DW-1:0]              din,
    output logic [$clog2(DW+1)-1:0]    cnt_c
);

    localparam int unsigned CW = $clog2(DW + 1);

    always_comb begin
        cnt_c = '0;
        for (int unsigned i = 0; i < DW; i++) begin
            cnt_c = cnt_c + CW'(din[i]);
        end
    end

endmodule

// File: rtl/freelist_ctrl.sv
// Free-list controller: rename handshake, shadow free count, flush recovery sequencing.
// Consistency checking (fl_err) is built only when NCPU_FL_CHECK_EN is defined.
module freelist_ctrl
    import freelist_ctrl_pkg::*;
#(
    parameter int unsigned CONFIG_PRF_AW         = 6,
    parameter int unsigned CONFIG_P_ISSUE_WIDTH  = 1,
    parameter int unsigned CONFIG_P_COMMIT_WIDTH = 1,
    parameter int unsigned CONFIG_N_ARF          = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   rn_valid,
    input  logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]   rn_lrd_we,
    output logic                                   rn_ready,
    output logic                                   fl_pop,
    input  logic                                   fl_stall_req,
    input  logic                                   flush_req,
    input  logic                                   commit_inflight,
    input  logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]  commit_fl_push,
    input  logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]  commit_prd_we,
    output logic                                   fl_rollback,
    output logic                                   flush_done,
    output logic [CONFIG_PRF_AW:0]                 fl_cnt,
    output logic                                   fl_err
);

    localparam int unsigned IW         = 1 << CONFIG_P_ISSUE_WIDTH;
    localparam int unsigned CW         = 1 << CONFIG_P_COMMIT_WIDTH;
    localparam int unsigned CNT_W      = CONFIG_PRF_AW + 1;
    localparam int unsigned NEED_W     = $clog2(IW + 1);
    localparam int unsigned FREED_W    = $clog2(CW + 1);
    localparam int unsigned FL_RST_CNT = fl_rst_cnt(CONFIG_PRF_AW, CONFIG_N_ARF);

    fl_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NEED_W-1:0]  need_c;
    logic [FREED_W-1:0] freed_c;
    logic               short_c;
    logic               stall_c;
    logic [CNT_W-1:0]   cnt_nxt_c;

    popcnt #(.DW(IW)) u_need (
        .din   (rn_lrd_we),
        .cnt_c (need_c)
    );

    popcnt #(.DW(CW)) u_freed (
        .din   (commit_fl_push & commit_prd_we),
        .cnt_c (freed_c)
    );

    assign short_c   = cnt_q < CNT_W'(need_c);
    assign stall_c   = fl_stall_req | short_c;
    assign fl_pop    = rn_valid & rn_ready;
    assign cnt_nxt_c = cnt_q - (fl_pop ? CNT_W'(need_c) : CNT_W'(0)) + CNT_W'(freed_c);
    assign fl_cnt    = cnt_q;

    // Next-state and state-decoded outputs; flush wins over acceptance in RUN.
    always_comb begin
        state_d     = state_q;
        rn_ready    = 1'b0;
        fl_rollback = 1'b0;
        flush_done  = 1'b0;
        case (state_q)
            ST_RUN: begin
                rn_ready = ~stall_c & ~flush_req;
                if (flush_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!commit_inflight && (commit_fl_push == '0)) begin
                    state_d = ST_ROLLBACK;
                end
            end
            ST_ROLLBACK: begin
                fl_rollback = 1'b1;
                state_d     = ST_SETTLE;
            end
            ST_SETTLE: begin
                flush_done = 1'b1;
                state_d    = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Rollback restores the architectural free count; otherwise pops and frees accumulate.
    always_comb begin
        cnt_d = cnt_nxt_c;
        if (state_q == ST_ROLLBACK) begin
            cnt_d = CNT_W'(FL_RST_CNT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= CNT_W'(FL_RST_CNT);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef NCPU_FL_CHECK_EN
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned N_PRF = 1 << CONFIG_PRF_AW;

    logic             err_q, err_d;
    logic [SUM_W-1:0] cnt_wide_c;

    assign cnt_wide_c = SUM_W'(cnt_q) - (fl_pop ? SUM_W'(need_c) : SUM_W'(0)) + SUM_W'(freed_c);

    // Sticky: over-allocation, count/stall disagreement, overflow, or commits during rollback.
    always_comb begin
        err_d = err_q;
        if (fl_pop && short_c) begin
            err_d = 1'b1;
        end
        if (!fl_stall_req && rn_valid && short_c) begin
            err_d = 1'b1;
        end
        if ((state_q != ST_ROLLBACK) && (cnt_wide_c > SUM_W'(N_PRF))) begin
            err_d = 1'b1;
        end
        if ((state_q == ST_ROLLBACK) && (freed_c != '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign fl_err = err_q;
`else
    assign fl_err = 1'b0;
`endif

endmodule
